// File: rtl/spi_reg_controller_if.sv
// spi_reg_controller_if: SPI queue and register-bank signals of the command sequencer
interface spi_reg_controller_if #(
  parameter int WORD_SIZE  = 8,
  parameter int ADDR_WIDTH = 7
);
  logic                  spi_active;
  logic                  rx_ready;
  logic                  rx_data_en;
  logic [WORD_SIZE-1:0]  rx_data;
  logic                  tx_ready;
  logic                  tx_data_en;
  logic [WORD_SIZE-1:0]  tx_data;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic                  reg_we;
  logic [WORD_SIZE-1:0]  reg_wdata;
  logic                  reg_re;
  logic [WORD_SIZE-1:0]  reg_rdata;
  modport master (
    input  spi_active, rx_ready, rx_data, tx_ready, reg_rdata,
    output rx_data_en, tx_data_en, tx_data, reg_addr, reg_we, reg_wdata, reg_re
  );
  modport slave (
    output spi_active, rx_ready, rx_data, tx_ready, reg_rdata,
    input  rx_data_en, tx_data_en, tx_data, reg_addr, reg_we, reg_wdata, reg_re
  );
endinterface

// File: rtl/spi_reg_controller.sv
// spi_reg_controller: SPI command sequencer doing burst register reads/writes; SPI_REG_CTRL_CHECKSUM_EN adds an XOR checksum word
module spi_reg_controller #(
  parameter int WORD_SIZE  = 8,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  spi_reg_controller_if.master bus,
  output logic                 busy,
  output logic                 err_abort,
  output logic                 err_checksum
);
  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_LEN_REQ, S_LEN, S_WR_REQ, S_WR, S_RD_REQ, S_RD_HOLD, S_FLUSH
`ifdef SPI_REG_CTRL_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;
`ifdef SPI_REG_CTRL_CHECKSUM_EN
  localparam state_t S_DONE = S_CHK;
`else
  localparam state_t S_DONE = S_IDLE;
`endif
  state_t                state, state_n;
  logic                  dir, dir_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [WORD_SIZE-1:0]  cnt, cnt_n;
  logic [WORD_SIZE-1:0]  hold, hold_n;
  logic [WORD_SIZE-1:0]  word;
  logic                  got, got_n;
  logic                  lost, wait_st, last;
`ifdef SPI_REG_CTRL_CHECKSUM_EN
  logic [WORD_SIZE-1:0]  csum, csum_n;
  logic                  chk, chk_n;
  assign err_checksum = chk;
  assign wait_st = state inside {S_LEN_REQ, S_WR_REQ, S_RD_REQ, S_RD_HOLD} || (state == S_CHK && !got);
`else
  assign err_checksum = 1'b0;
  assign wait_st = state inside {S_LEN_REQ, S_WR_REQ, S_RD_REQ, S_RD_HOLD};
`endif
  assign busy = state != S_IDLE;
  assign lost = !bus.spi_active && !bus.rx_ready;
  assign last = cnt == WORD_SIZE'(1);
  // state and datapath registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= S_IDLE;
      dir   <= 1'b0;
      addr  <= '0;
      cnt   <= '0;
      hold  <= '0;
      got   <= 1'b0;
`ifdef SPI_REG_CTRL_CHECKSUM_EN
      csum  <= '0;
      chk   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      dir   <= dir_n;
      addr  <= addr_n;
      cnt   <= cnt_n;
      hold  <= hold_n;
      got   <= got_n;
`ifdef SPI_REG_CTRL_CHECKSUM_EN
      csum  <= csum_n;
      chk   <= chk_n;
`endif
    end
  end
  // next-state and outputs; a lost transfer in a waiting state aborts before any access
  always_comb begin
    state_n        = state;
    dir_n          = dir;
    addr_n         = addr;
    cnt_n          = cnt;
    hold_n         = hold;
    got_n          = 1'b0;
`ifdef SPI_REG_CTRL_CHECKSUM_EN
    csum_n         = csum;
    chk_n          = chk;
`endif
    word           = got ? hold : bus.reg_rdata;
    bus.rx_data_en = 1'b0;
    bus.tx_data_en = 1'b0;
    bus.tx_data    = '0;
    bus.reg_addr   = '0;
    bus.reg_we     = 1'b0;
    bus.reg_wdata  = '0;
    bus.reg_re     = 1'b0;
    err_abort      = 1'b0;
    if (lost && wait_st) begin
      err_abort = 1'b1;
      state_n   = S_FLUSH;
    end else begin
      case (state)
        S_IDLE: if (bus.rx_ready) begin
          bus.rx_data_en = 1'b1;
          state_n        = S_CMD;
        end
        S_CMD: begin
          dir_n   = bus.rx_data[WORD_SIZE-1];
          addr_n  = bus.rx_data[ADDR_WIDTH-1:0];
`ifdef SPI_REG_CTRL_CHECKSUM_EN
          csum_n  = '0;
          chk_n   = 1'b0;
`endif
          state_n = S_LEN_REQ;
        end
        S_LEN_REQ: if (bus.rx_ready) begin
          bus.rx_data_en = 1'b1;
          state_n        = S_LEN;
        end
        S_LEN: begin
          cnt_n   = bus.rx_data;
          state_n = bus.rx_data == '0 ? S_DONE : (dir ? S_RD_REQ : S_WR_REQ);
        end
        S_WR_REQ: if (bus.rx_ready) begin
          bus.rx_data_en = 1'b1;
          state_n        = S_WR;
        end
        S_WR: begin
          bus.reg_we    = 1'b1;
          bus.reg_wdata = bus.rx_data;
          bus.reg_addr  = addr;
          addr_n        = addr + 1'b1;
          cnt_n         = cnt - 1'b1;
`ifdef SPI_REG_CTRL_CHECKSUM_EN
          csum_n        = csum ^ bus.rx_data;
`endif
          state_n       = last ? S_DONE : S_WR_REQ;
        end
        S_RD_REQ: begin
          bus.reg_re   = 1'b1;
          bus.reg_addr = addr;
          state_n      = S_RD_HOLD;
        end
        S_RD_HOLD: begin
          hold_n = word;
          if (bus.tx_ready) begin
            bus.tx_data_en = 1'b1;
            bus.tx_data    = word;
            addr_n         = addr + 1'b1;
            cnt_n          = cnt - 1'b1;
`ifdef SPI_REG_CTRL_CHECKSUM_EN
            csum_n         = csum ^ word;
`endif
            state_n        = last ? S_DONE : S_RD_REQ;
          end else begin
            got_n = 1'b1;
          end
        end
        S_FLUSH: begin
          bus.rx_data_en = bus.rx_ready && !bus.spi_active;
          state_n        = bus.rx_data_en ? S_FLUSH : S_IDLE;
        end
`ifdef SPI_REG_CTRL_CHECKSUM_EN
        S_CHK: begin
          if (dir) begin
            bus.tx_data = bus.tx_ready ? csum : '0;
            bus.tx_data_en = bus.tx_ready;
            state_n     = bus.tx_ready ? S_IDLE : S_CHK;
          end else if (got) begin
            chk_n   = chk | (bus.rx_data != csum);
            state_n = S_IDLE;
          end else if (bus.rx_ready) begin
            bus.rx_data_en = 1'b1;
            got_n          = 1'b1;
          end
        end
`endif
        default: state_n = S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_reg_controller.sv
// tb_spi_reg_controller: directed scoreboard bench for spi_reg_controller
module tb_spi_reg_controller;
  localparam int W = 8;
  localparam int A = 7;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, err_abort, err_checksum;
  spi_reg_controller_if #(.WORD_SIZE(W), .ADDR_WIDTH(A)) bus ();
  spi_reg_controller #(.WORD_SIZE(W), .ADDR_WIDTH(A)) dut (
    .sys_clk(clk), .sys_rst(rst), .bus(bus),
    .busy(busy), .err_abort(err_abort), .err_checksum(err_checksum)
  );
  always #5 clk = ~clk;
  int vectors = 0;
  int errors = 0;
  int proto = 0;
  int aborts = 0;
  logic [W-1:0] rxq[$];
  logic [W-1:0] txq[$];
  logic [15:0] wrq[$];
  logic [W-1:0] next_rx = '0;
  logic [A-1:0] rd_addr = '0;
  logic pend_pop = 1'b0;
  logic pend_rd = 1'b0;
  logic spi_act = 1'b1;
  logic tx_rdy = 1'b1;

  function automatic logic [W-1:0] rmodel(logic [A-1:0] a);
    return {1'b0, a} ^ 8'h40;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one cycle: drive inputs at negedge, then observe the settled outputs
  task automatic tick();
    logic [15:0] e;
    @(negedge clk);
    if (pend_pop) bus.rx_data = next_rx;
    if (pend_rd) bus.reg_rdata = rmodel(rd_addr);
    bus.rx_ready = rxq.size() != 0;
    bus.spi_active = spi_act;
    bus.tx_ready = tx_rdy;
    #1;
    pend_pop = bus.rx_data_en;
    pend_rd = bus.reg_re;
    if (bus.rx_data_en) begin
      if (!bus.rx_ready) proto++;
      if (rxq.size() != 0) next_rx = rxq.pop_front();
    end
    if (bus.reg_re) begin
      rd_addr = bus.reg_addr;
      if (bus.reg_we) proto++;
    end
    if (bus.tx_data_en && !bus.tx_ready) proto++;
    if (err_abort) aborts++;
    if (bus.reg_we) begin
      e = wrq.size() != 0 ? wrq.pop_front() : 16'hffff;
      check("reg_write", {16'h0, 1'b0, bus.reg_addr, bus.reg_wdata}, {16'h0, e});
    end
    if (bus.tx_data_en) begin
      e = txq.size() != 0 ? {8'h0, txq.pop_front()} : 16'hffff;
      check("tx_push", {24'h0, bus.tx_data}, {16'h0, e});
    end
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic settle(string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while ((busy || rxq.size() != 0 || pend_pop || pend_rd) && n < 300);
    check({tag, "_idle"}, {31'h0, busy}, 0);
    check({tag, "_wr_left"}, wrq.size(), 0);
    check({tag, "_tx_left"}, txq.size(), 0);
  endtask

  task automatic wr_cmd(logic [A-1:0] a, logic [W-1:0] d0, logic [W-1:0] d1);
    rxq.push_back({1'b0, a});
    rxq.push_back(8'h02);
    rxq.push_back(d0);
    rxq.push_back(d1);
    wrq.push_back({1'b0, a, d0});
    wrq.push_back({1'b0, a + 7'd1, d1});
`ifdef SPI_REG_CTRL_CHECKSUM_EN
    rxq.push_back(d0 ^ d1);
`endif
  endtask

  task automatic rd_cmd(logic [A-1:0] a);
    rxq.push_back({1'b1, a});
    rxq.push_back(8'h02);
    txq.push_back(rmodel(a));
    txq.push_back(rmodel(a + 7'd1));
`ifdef SPI_REG_CTRL_CHECKSUM_EN
    txq.push_back(rmodel(a) ^ rmodel(a + 7'd1));
`endif
  endtask

  initial begin
    int n;
    bus.rx_data = '0;
    bus.reg_rdata = '0;
    ticks(3);
    check("reset_outputs", {2'b0, busy, err_abort, err_checksum, bus.rx_data_en, bus.tx_data_en,
          bus.reg_we, bus.reg_re, bus.tx_data, bus.reg_addr, bus.reg_wdata}, 0);
    rst = 1'b0;
    wr_cmd(7'h05, 8'hAA, 8'hBB);
    settle("write");
    tx_rdy = 1'b0;
    rd_cmd(7'h03);
    ticks(12);
    check("read_stalled", txq.size(), `ifdef SPI_REG_CTRL_CHECKSUM_EN 3 `else 2 `endif);
    check("read_busy", {31'h0, busy}, 1);
    tx_rdy = 1'b1;
    settle("read");
    wr_cmd(7'h7F, 8'h11, 8'h22);
    settle("wrap");
    rxq.push_back(8'h10);
    rxq.push_back(8'h03);
    rxq.push_back(8'h01);
    wrq.push_back({1'b0, 7'h10, 8'h01});
    ticks(10);
    check("abort_one_write", wrq.size(), 0);
    n = aborts;
    spi_act = 1'b0;
    ticks(5);
    check("abort_pulses", aborts - n, 1);
    check("abort_idle", {31'h0, busy}, 0);
    spi_act = 1'b1;
    ticks(2);
    rxq.push_back(8'h20);
    rxq.push_back(8'h05);
    rxq.push_back(8'h01);
    wrq.push_back({1'b0, 7'h20, 8'h01});
    ticks(10);
    n = aborts;
    spi_act = 1'b0;
    for (int i = 0; i < 10 && aborts == n; i++) tick();
    rxq.push_back(8'h55);
    rxq.push_back(8'h66);
    ticks(6);
    check("flush_abort", aborts - n, 1);
    check("flush_drained", rxq.size(), 0);
    check("flush_idle", {31'h0, busy}, 0);
    check("flush_no_write", wrq.size(), 0);
    spi_act = 1'b1;
    ticks(2);
`ifdef SPI_REG_CTRL_CHECKSUM_EN
    rxq.push_back(8'h00);
    rxq.push_back(8'h02);
    rxq.push_back(8'h0F);
    rxq.push_back(8'hF0);
    rxq.push_back(8'hFE);
    wrq.push_back({1'b0, 7'h00, 8'h0F});
    wrq.push_back({1'b0, 7'h01, 8'hF0});
    settle("csum_bad");
    check("csum_flag_set", {31'h0, err_checksum}, 1);
    wr_cmd(7'h40, 8'h12, 8'h34);
    settle("csum_good");
    check("csum_flag_clear", {31'h0, err_checksum}, 0);
`endif
    check("handshake_rules", proto, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
